// File: rtl/loader_pkg.sv
// Shared state encodings, framing constants and byte-level helpers for the
// boot-image program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT_LO = 3'd1,
        ST_COUNT_HI = 3'd2,
        ST_DATA     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_RUN      = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    function automatic logic accepts_bytes(input state_e st);
        logic ok;
        case (st)
            ST_COUNT_LO, ST_COUNT_HI, ST_DATA, ST_CHECK: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader owns the master side: it drives in_ready and the write strobe.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 64
) ();
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  im_write_en;
    logic [ADDR_WIDTH-1:0] im_write_address;
    logic [31:0]           im_write_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, im_write_en, im_write_address, im_write_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, im_write_en, im_write_address, im_write_data
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects four stream bytes (least-significant first) into a 32-bit word and
// flags the byte that completes it.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_complete
);

    // Only the first three bytes are held; the fourth is merged on the fly.
    logic [23:0] shift_r;
    logic [1:0]  idx_r;

    // Shift accepted bytes in and track the position within the word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_r <= 24'd0;
            idx_r   <= 2'd0;
        end else if (byte_en) begin
            shift_r <= {byte_data, shift_r[23:8]};
            idx_r   <= idx_r + 2'd1;
        end
    end

    // Present the assembled word and completion flag.
    always_comb begin
        word_next     = {byte_data, shift_r};
        word_complete = byte_en && (idx_r == 2'(WORD_BYTES - 1));
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a counted, checksummed byte stream into instruction
// memory writes and releases the core once the image verifies.
module program_loader
    import loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.master bus,
    output logic             core_hold,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    state_e                state_r;
    state_e                state_s;
    logic [7:0]            count_lo_r;
    logic [15:0]           count_r;
    logic [7:0]            csum_r;
    logic [15:0]           words_r;
    logic                  in_ready_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           data_r;
    logic                  core_hold_r;
    logic                  done_r;
    logic                  error_r;

    logic                  transfer_s;
    logic                  data_byte_s;
    logic [15:0]           count_hdr_s;
    logic                  last_word_s;
    logic [ADDR_WIDTH-1:0] write_addr_s;
    logic [31:0]           word_next_s;
    logic                  word_complete_s;

    word_assembler u_assembler (
        .clock         (clock),
        .reset         (reset),
        .byte_en       (data_byte_s),
        .byte_data     (bus.in_data),
        .word_next     (word_next_s),
        .word_complete (word_complete_s)
    );

    // Handshake decode, header count and the next write address.
    always_comb begin
        transfer_s   = bus.in_valid && in_ready_r;
        data_byte_s  = transfer_s && (state_r == ST_DATA);
        count_hdr_s  = {bus.in_data, count_lo_r};
        last_word_s  = ((words_r + 16'd1) == count_r);
        write_addr_s = BASE_ADDR + ADDR_WIDTH'({words_r, 2'b00});
    end

    // Next-state logic; without a transfer every state holds.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = ST_COUNT_LO;
            ST_COUNT_LO: begin
                if (transfer_s) state_s = ST_COUNT_HI;
                else            state_s = state_r;
            end
            ST_COUNT_HI: begin
                if (!transfer_s)                                 state_s = state_r;
                else if ({1'b0, count_hdr_s} > 17'(MAX_WORDS))   state_s = ST_ERROR;
                else if (count_hdr_s == 16'd0)                   state_s = ST_CHECK;
                else                                             state_s = ST_DATA;
            end
            ST_DATA: begin
                if (word_complete_s && last_word_s) state_s = ST_CHECK;
                else                                state_s = state_r;
            end
            ST_CHECK: begin
                if (!transfer_s)                state_s = state_r;
                else if (bus.in_data == csum_r) state_s = ST_RUN;
                else                            state_s = ST_ERROR;
            end
            ST_RUN:   state_s = ST_RUN;
            ST_ERROR: state_s = ST_ERROR;
            default:  state_s = ST_ERROR;
        endcase
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= accepts_bytes(state_s);
            core_hold_r <= (state_s != ST_RUN);
            done_r      <= (state_s == ST_RUN);
            error_r     <= (state_s == ST_ERROR);
        end
    end

    // Header capture and running checksum over every byte before the check byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_lo_r <= 8'd0;
            count_r    <= 16'd0;
            csum_r     <= 8'd0;
        end else if (transfer_s) begin
            if (state_r == ST_COUNT_LO) count_lo_r <= bus.in_data;
            if (state_r == ST_COUNT_HI) count_r    <= count_hdr_s;
            if (state_r == ST_COUNT_LO || state_r == ST_COUNT_HI || state_r == ST_DATA) begin
                csum_r <= csum_update(csum_r, bus.in_data);
            end
        end
    end

    // One-cycle write strobe per completed word; address/data hold afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            data_r  <= 32'd0;
            words_r <= 16'd0;
        end else begin
            we_r <= word_complete_s;
            if (word_complete_s) begin
                addr_r  <= write_addr_s;
                data_r  <= word_next_s;
                words_r <= words_r + 16'd1;
            end
        end
    end

    assign bus.in_ready         = in_ready_r;
    assign bus.im_write_en      = we_r;
    assign bus.im_write_address = addr_r;
    assign bus.im_write_data    = data_r;
    assign core_hold            = core_hold_r;
    assign done                 = done_r;
    assign error                = error_r;
    assign words_loaded         = words_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: known-good, bad-checksum, empty,
// oversize, stalled and reset-interrupted images.
module tb_program_loader;
    import loader_pkg::*;

    localparam int STREAM_LEN = HDR_BYTES + 2 * WORD_BYTES + 1;
    localparam int LOG_DEPTH  = 16;

    logic        clock;
    logic        reset;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int vectors;
    int miscompares;
    int n_writes;
    int base;

    logic [63:0] log_addr [LOG_DEPTH];
    logic [31:0] log_data [LOG_DEPTH];
    logic [7:0]  img      [STREAM_LEN];

    program_loader_if #(.ADDR_WIDTH(64)) bus ();

    program_loader #(
        .ADDR_WIDTH (64),
        .BASE_ADDR  (64'h0),
        .MAX_WORDS  (1024)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every write strobe away from the active edge.
    always @(negedge clock) begin
        if (bus.im_write_en === 1'b1) begin
            if (n_writes < LOG_DEPTH) begin
                log_addr[n_writes] = bus.im_write_address;
                log_data[n_writes] = bus.im_write_data;
            end
            n_writes = n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic rdy;
        int   waited;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        do begin
            rdy = bus.in_ready;
            @(posedge clock); #1;
            waited++;
        end while (rdy !== 1'b1 && waited < 20);
        check("byte_accepted_within_bound", {63'd0, rdy}, 64'd1);
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic send_stream(input logic [7:0] last, input bit gap);
        for (int i = 0; i < STREAM_LEN - 1; i++) send_byte(img[i], gap);
        send_byte(last, gap);
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        base  = n_writes;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_writes    = 0;
        base        = 0;
        img[0] = 8'h02; img[1] = 8'h00;
        img[2] = 8'h93; img[3] = 8'h00; img[4] = 8'h50; img[5] = 8'h00;
        img[6] = 8'h33; img[7] = 8'h81; img[8] = 8'h10; img[9] = 8'h00;
        img[10] = 8'h63;

        // Reset values
        apply_reset();
        check("rst_in_ready",  {63'd0, bus.in_ready},    64'd0);
        check("rst_we",        {63'd0, bus.im_write_en}, 64'd0);
        check("rst_addr",      bus.im_write_address,     64'd0);
        check("rst_data",      {32'd0, bus.im_write_data}, 64'd0);
        check("rst_core_hold", {63'd0, core_hold},       64'd1);
        check("rst_done",      {63'd0, done},            64'd0);
        check("rst_error",     {63'd0, error},           64'd0);
        check("rst_words",     {48'd0, words_loaded},    64'd0);
        release_reset();
        @(posedge clock); #1;
        check("count_lo_ready", {63'd0, bus.in_ready}, 64'd1);

        // Good two-word image, in_valid held high
        send_stream(8'h63, 1'b0);
        repeat (2) @(posedge clock); #1;
        check("good_nwrites",  64'(n_writes - base),       64'd2);
        check("good_addr0",    log_addr[base],             64'h0);
        check("good_data0",    {32'd0, log_data[base]},    64'h00500093);
        check("good_addr1",    log_addr[base + 1],         64'h4);
        check("good_data1",    {32'd0, log_data[base + 1]}, 64'h00108133);
        check("good_done",     {63'd0, done},              64'd1);
        check("good_core_hold", {63'd0, core_hold},        64'd0);
        check("good_error",    {63'd0, error},             64'd0);
        check("good_words",    {48'd0, words_loaded},      64'd2);
        check("good_ready",    {63'd0, bus.in_ready},      64'd0);

        // Same image, corrupted checksum
        apply_reset();
        release_reset();
        send_stream(8'h64, 1'b0);
        repeat (2) @(posedge clock); #1;
        check("badck_nwrites", 64'(n_writes - base),  64'd2);
        check("badck_error",   {63'd0, error},        64'd1);
        check("badck_done",    {63'd0, done},         64'd0);
        check("badck_hold",    {63'd0, core_hold},    64'd1);
        check("badck_ready",   {63'd0, bus.in_ready}, 64'd0);

        // Empty image
        apply_reset();
        release_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (2) @(posedge clock); #1;
        check("empty_nwrites", 64'(n_writes - base), 64'd0);
        check("empty_done",    {63'd0, done},        64'd1);
        check("empty_hold",    {63'd0, core_hold},   64'd0);

        // Oversize count 0x0401
        apply_reset();
        release_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        check("big_error_next_cycle", {63'd0, error},        64'd1);
        check("big_ready",            {63'd0, bus.in_ready}, 64'd0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clock); #1;
        check("big_nwrites", 64'(n_writes - base), 64'd0);
        check("big_done",    {63'd0, done},        64'd0);

        // Good image with in_valid toggling every cycle
        apply_reset();
        release_reset();
        send_stream(8'h63, 1'b1);
        repeat (2) @(posedge clock); #1;
        check("tog_nwrites", 64'(n_writes - base),        64'd2);
        check("tog_addr0",   log_addr[base],              64'h0);
        check("tog_data0",   {32'd0, log_data[base]},     64'h00500093);
        check("tog_addr1",   log_addr[base + 1],          64'h4);
        check("tog_data1",   {32'd0, log_data[base + 1]}, 64'h00108133);
        check("tog_done",    {63'd0, done},               64'd1);
        check("tog_words",   {48'd0, words_loaded},       64'd2);

        // Reset after the sixth byte, then a full reload
        apply_reset();
        release_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        check("abort_words_before", {48'd0, words_loaded}, 64'd1);
        apply_reset();
        check("abort_nwrites",  64'(n_writes - base),  64'd1);
        check("abort_addr0",    log_addr[base],        64'h0);
        check("abort_we_rst",   {63'd0, bus.im_write_en}, 64'd0);
        check("abort_words_rst", {48'd0, words_loaded}, 64'd0);
        release_reset();
        send_stream(8'h63, 1'b0);
        repeat (2) @(posedge clock); #1;
        check("reload_nwrites", 64'(n_writes - base),        64'd2);
        check("reload_data1",   {32'd0, log_data[base + 1]}, 64'h00108133);
        check("reload_done",    {63'd0, done},               64'd1);
        check("reload_words",   {48'd0, words_loaded},       64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 64 and SHALL set the width of the instruction-memory write address.
REQ-002 Parameter BASE_ADDR SHALL default to 0 and SHALL be the byte address of the first loaded word.
REQ-003 Parameter MAX_WORDS SHALL default to 1024 and SHALL be the largest accepted word count.
REQ-004 There SHALL be one clock; reset is asynchronous and active-low.
REQ-005 Port clock: input, 1 bit, sole clock, all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit, asynchronous active-low reset.
REQ-007 Port in_valid: input, 1 bit, byte-stream source has a byte.
REQ-008 Port in_data: input, 8 bits, stream byte.
REQ-009 Port in_ready: output, 1 bit, loader accepts a byte; transfer occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-010 Port im_write_en: output, 1 bit, instruction-memory write strobe.
REQ-011 Port im_write_address: output, ADDR_WIDTH bits, instruction-memory byte address.
REQ-012 Port im_write_data: output, 32 bits, instruction word.
REQ-013 Port core_hold: output, 1 bit, holds the processor in reset while 1.
REQ-014 Port done: output, 1 bit, image loaded and verified.
REQ-015 Port error: output, 1 bit, load failed.
REQ-016 Port words_loaded: output, 16 bits, count of words written so far.

Function
REQ-017 Image format SHALL be: count low byte, count high byte, then count words of 4 bytes each, least-significant byte first, then 1 checksum byte.
REQ-018 The checksum SHALL equal the XOR of every byte preceding it, including both count bytes.
REQ-019 States SHALL be IDLE, COUNT_LO, COUNT_HI, DATA, CHECK, RUN, ERROR.
REQ-020 IDLE SHALL go to COUNT_LO on the first clock after reset release, unconditionally.
REQ-021 COUNT_LO SHALL go to COUNT_HI on transfer.
REQ-022 COUNT_HI SHALL go, on transfer, to ERROR if the count exceeds MAX_WORDS, else to CHECK if the count is 0, else to DATA.
REQ-023 DATA SHALL go to CHECK on the transfer of the last byte of the last word.
REQ-024 CHECK SHALL go, on transfer, to RUN if the checksum matches, else to ERROR.
REQ-025 RUN and ERROR SHALL be terminal until reset.
REQ-026 in_ready SHALL be 1 in COUNT_LO, COUNT_HI, DATA and CHECK, and 0 in IDLE, RUN and ERROR.
REQ-027 A cycle with in_valid=0 SHALL leave all state unchanged, so stalls of any length are tolerated.
REQ-028 On the clock edge that accepts the 4th byte of word i, im_write_en SHALL be 1 for exactly the next cycle, with im_write_address=BASE_ADDR+4*i and im_write_data equal to the assembled word.
REQ-029 words_loaded SHALL increment in the same cycle im_write_en is 1.
REQ-030 The address SHALL be computed modulo 2^ADDR_WIDTH.
REQ-031 in_ready SHALL stay 1 during the write-strobe cycle, and a byte accepted in that cycle SHALL be processed normally.
REQ-032 im_write_en SHALL be 0 in every other cycle.
REQ-033 core_hold SHALL be 1 in all states except RUN.
REQ-034 done SHALL be 1 only in RUN; error SHALL be 1 only in ERROR.
REQ-035 No memory write SHALL occur after the checksum byte or in ERROR.

Reset
REQ-036 While reset=0 the state SHALL be IDLE, with in_ready=0, im_write_en=0, im_write_address=0, im_write_data=0, core_hold=1, done=0, error=0, words_loaded=0.
REQ-037 The checksum accumulator, byte index and word count SHALL clear on reset.
REQ-038 Reset asserted mid-load SHALL abort immediately, with no further write strobes, and the load SHALL restart from COUNT_LO after release.

Structure
REQ-039 Package loader_pkg SHALL hold the state encodings and the header and word byte-count localparams.
REQ-040 Sub-module word_assembler SHALL shift four bytes into a 32-bit word and flag completion; the FSM, counters and checksum SHALL remain in program_loader.

Verification
REQ-041 Stream bytes 02 00 93 00 50 00 33 81 10 00 63 with in_valid always 1 -> writes (0x0, 0x00500093) then (0x4, 0x00108133); done=1, core_hold=0, words_loaded=2.
REQ-042 Same stream with the last byte 0x64 -> two writes, then error=1, done=0, core_hold=1, in_ready=0.
REQ-043 Stream 00 00 00 -> no writes; done=1.
REQ-044 Count bytes 01 04 (1025 > MAX_WORDS) -> error=1 the cycle after the second byte; no writes.
REQ-045 REQ-041 stream with in_valid toggled 1/0 every cycle -> identical writes and result.
REQ-046 Reset asserted after the 6th byte of REQ-041 -> exactly one write in total; after release, resending the full stream -> done=1.
